// File: rtl/bresp_merge.sv
// Write-response merger: per-ID in-order queues of sub-transaction totals, folding
// downstream B beats into one worst-case upstream B. Optional: BRESP_MERGE_ERR_CNT_EN.
module bresp_merge #(
    parameter int ID_WIDTH      = 3,
    parameter int RESP_WIDTH    = 2,
    parameter int SUB_CNT_WIDTH = 3,
    parameter int DEPTH         = 4
) (
    input  logic                     aclk,
    input  logic                     arst,
    input  logic                     aw_valid,
    output logic                     aw_ready,
    input  logic [ID_WIDTH-1:0]      aw_id,
    input  logic [SUB_CNT_WIDTH-1:0] aw_total_sub,
    input  logic                     s_b_valid,
    output logic                     s_b_ready,
    input  logic [ID_WIDTH-1:0]      s_bid,
    input  logic [RESP_WIDTH-1:0]    s_bresp,
    output logic                     m_b_valid,
    input  logic                     m_b_ready,
    output logic [ID_WIDTH-1:0]      m_bid,
    output logic [RESP_WIDTH-1:0]    m_bresp,
    output logic                     err_unexp
`ifdef BRESP_MERGE_ERR_CNT_EN
    ,
    output logic [15:0]              err_cnt
`endif
);

    localparam int NUM_IDS = 2**ID_WIDTH;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int ADDR_W  = ID_WIDTH + PTR_W;

    localparam logic [RESP_WIDTH-1:0]    RESP_EXOKAY = RESP_WIDTH'(1);
    localparam logic [OCC_W-1:0]         OCC_FULL    = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0]         OCC_ONE     = OCC_W'(1);
    localparam logic [PTR_W-1:0]         PTR_ONE     = PTR_W'(1);
    localparam logic [SUB_CNT_WIDTH-1:0] CNT_ONE     = SUB_CNT_WIDTH'(1);
    localparam logic [SUB_CNT_WIDTH:0]   CNT_ONE_EXT = (SUB_CNT_WIDTH + 1)'(1);

    // Severity order DECERR > SLVERR > OKAY > EXOKAY; EXOKAY is the identity.
    function automatic logic [1:0] resp_rank(input logic [RESP_WIDTH-1:0] r);
        logic [1:0] rank;
        case (r)
            RESP_WIDTH'(0): rank = 2'd1;
            RESP_WIDTH'(1): rank = 2'd0;
            RESP_WIDTH'(2): rank = 2'd2;
            default:        rank = 2'd3;
        endcase
        return rank;
    endfunction

    function automatic logic [RESP_WIDTH-1:0] resp_merge(
        input logic [RESP_WIDTH-1:0] a,
        input logic [RESP_WIDTH-1:0] b
    );
        return (resp_rank(b) > resp_rank(a)) ? b : a;
    endfunction

    // Per-ID queue state
    logic [SUB_CNT_WIDTH-1:0] r_total    [NUM_IDS*DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr   [NUM_IDS];
    logic [PTR_W-1:0]         r_rd_ptr   [NUM_IDS];
    logic [OCC_W-1:0]         r_occ      [NUM_IDS];
    logic [SUB_CNT_WIDTH-1:0] r_done_cnt [NUM_IDS];
    logic [RESP_WIDTH-1:0]    r_acc      [NUM_IDS];

    // Output registers
    logic                  r_m_b_valid;
    logic [ID_WIDTH-1:0]   r_m_bid;
    logic [RESP_WIDTH-1:0] r_m_bresp;
    logic                  r_err_unexp;

    logic                     w_aw_ready;
    logic                     w_aw_fire;
    logic                     w_aw_enq;
    logic                     w_aw_err;
    logic                     w_s_b_ready;
    logic                     w_b_fire;
    logic                     w_b_err;
    logic                     w_b_ok;
    logic                     w_final;
    logic                     w_err_now;
    logic [ADDR_W-1:0]        w_wr_addr;
    logic [ADDR_W-1:0]        w_rd_addr;
    logic [SUB_CNT_WIDTH-1:0] w_head_total;
    logic [SUB_CNT_WIDTH:0]   w_done_plus1;
    logic [RESP_WIDTH-1:0]    w_merged;

    // Admission uses registered occupancy only: a same-cycle pop never frees a slot.
    assign w_aw_ready = (r_occ[aw_id] < OCC_FULL);
    assign w_aw_fire  = aw_valid && w_aw_ready;
    assign w_aw_enq   = w_aw_fire && (aw_total_sub != '0);
    assign w_aw_err   = w_aw_fire && (aw_total_sub == '0);

    assign w_s_b_ready = !r_m_b_valid || m_b_ready;
    assign w_b_fire    = s_b_valid && w_s_b_ready;
    assign w_b_err     = w_b_fire && (r_occ[s_bid] == '0);
    assign w_b_ok      = w_b_fire && (r_occ[s_bid] != '0);

    assign w_wr_addr    = {aw_id, r_wr_ptr[aw_id]};
    assign w_rd_addr    = {s_bid, r_rd_ptr[s_bid]};
    assign w_head_total = r_total[w_rd_addr];
    assign w_done_plus1 = {1'b0, r_done_cnt[s_bid]} + CNT_ONE_EXT;
    assign w_merged     = resp_merge(r_acc[s_bid], s_bresp);
    assign w_final      = w_b_ok && (w_done_plus1 == {1'b0, w_head_total});
    assign w_err_now    = w_aw_err || w_b_err;

    // Totals are small; an asynchronous read keeps the final-beat decision in one cycle.
    always_ff @(posedge aclk) begin
        if (w_aw_enq) begin
            r_total[w_wr_addr] <= aw_total_sub;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IDS; gi = gi + 1) begin : g_id
            logic w_inc;
            logic w_pop;
            logic w_hit;

            assign w_inc = w_aw_enq && (aw_id == ID_WIDTH'(gi));
            assign w_pop = w_final  && (s_bid == ID_WIDTH'(gi));
            assign w_hit = w_b_ok   && (s_bid == ID_WIDTH'(gi));

            always_ff @(posedge aclk) begin
                if (arst) begin
                    r_occ[gi]      <= '0;
                    r_wr_ptr[gi]   <= '0;
                    r_rd_ptr[gi]   <= '0;
                    r_done_cnt[gi] <= '0;
                    r_acc[gi]      <= RESP_EXOKAY;
                end else begin
                    if (w_inc && !w_pop) begin
                        r_occ[gi] <= r_occ[gi] + OCC_ONE;
                    end else if (!w_inc && w_pop) begin
                        r_occ[gi] <= r_occ[gi] - OCC_ONE;
                    end
                    if (w_inc) begin
                        r_wr_ptr[gi] <= r_wr_ptr[gi] + PTR_ONE;
                    end
                    if (w_pop) begin
                        r_rd_ptr[gi]   <= r_rd_ptr[gi] + PTR_ONE;
                        r_done_cnt[gi] <= '0;
                        r_acc[gi]      <= RESP_EXOKAY;
                    end else if (w_hit) begin
                        r_done_cnt[gi] <= r_done_cnt[gi] + CNT_ONE;
                        r_acc[gi]      <= w_merged;
                    end
                end
            end
        end
    endgenerate

    // A completion during an upstream handshake reloads the slot for back-to-back output.
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_m_b_valid <= 1'b0;
            r_m_bid     <= '0;
            r_m_bresp   <= '0;
            r_err_unexp <= 1'b0;
        end else begin
            r_err_unexp <= w_err_now;
            if (w_final) begin
                r_m_b_valid <= 1'b1;
                r_m_bid     <= s_bid;
                r_m_bresp   <= w_merged;
            end else if (m_b_ready) begin
                r_m_b_valid <= 1'b0;
            end
        end
    end

`ifdef BRESP_MERGE_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_err_cnt <= '0;
        end else if (w_err_now && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign aw_ready  = w_aw_ready;
    assign s_b_ready = w_s_b_ready;
    assign m_b_valid = r_m_b_valid;
    assign m_bid     = r_m_bid;
    assign m_bresp   = r_m_bresp;
    assign err_unexp = r_err_unexp;

endmodule

// File: tb/tb_bresp_merge.sv
// Self-checking bench for bresp_merge: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_bresp_merge;

    localparam int ID_WIDTH = 3;
    localparam int NUM_IDS  = 8;
    localparam int DEPTH    = 4;

    logic       aclk = 1'b0;
    logic       arst = 1'b1;
    logic       aw_valid = 1'b0;
    logic       aw_ready;
    logic [2:0] aw_id = '0;
    logic [2:0] aw_total_sub = '0;
    logic       s_b_valid = 1'b0;
    logic       s_b_ready;
    logic [2:0] s_bid = '0;
    logic [1:0] s_bresp = '0;
    logic       m_b_valid;
    logic       m_b_ready = 1'b1;
    logic [2:0] m_bid;
    logic [1:0] m_bresp;
    logic       err_unexp;
`ifdef BRESP_MERGE_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    always #5 aclk = ~aclk;

    bresp_merge #(
        .ID_WIDTH(ID_WIDTH), .RESP_WIDTH(2), .SUB_CNT_WIDTH(3), .DEPTH(DEPTH)
    ) dut (
        .aclk(aclk), .arst(arst),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_total_sub(aw_total_sub),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_bid(s_bid), .s_bresp(s_bresp),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_bid(m_bid), .m_bresp(m_bresp),
        .err_unexp(err_unexp)
`ifdef BRESP_MERGE_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: one queue of outstanding totals per ID
    int         q_tot [NUM_IDS][$];
    int         m_done [NUM_IDS];
    logic [1:0] m_worst [NUM_IDS];
    logic       exp_mv;
    logic [2:0] exp_bid;
    logic [1:0] exp_resp;
    logic       exp_err;
    int         exp_cnt;

    function automatic int severity(input logic [1:0] c);
        case (c)
            2'd1:    return 0;
            2'd0:    return 1;
            2'd2:    return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_IDS; i++) begin
            q_tot[i].delete();
            m_done[i]  = 0;
            m_worst[i] = 2'd1;
        end
        exp_mv   = 1'b0;
        exp_bid  = '0;
        exp_resp = '0;
        exp_err  = 1'b0;
        exp_cnt  = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, clock, update model, check registers.
    task automatic step(input logic rst, input logic awv, input logic [2:0] awid,
                        input logic [2:0] awtot, input logic bv, input logic [2:0] bid,
                        input logic [1:0] bresp, input logic mr);
        logic awr, sbr, comp, err;
        logic [1:0] c_resp;
        arst = rst; aw_valid = awv; aw_id = awid; aw_total_sub = awtot;
        s_b_valid = bv; s_bid = bid; s_bresp = bresp; m_b_ready = mr;
        @(negedge aclk);
        awr = (q_tot[awid].size() < DEPTH);
        sbr = !exp_mv || mr;
        if (!rst) begin
            chk("aw_ready", 32'(aw_ready), 32'(awr));
            chk("s_b_ready", 32'(s_b_ready), 32'(sbr));
        end
        @(posedge aclk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            comp = 1'b0; err = 1'b0; c_resp = 2'd0;
            if (bv && sbr) begin
                if (q_tot[bid].size() == 0) begin
                    err = 1'b1;
                end else begin
                    m_done[bid]++;
                    if (severity(bresp) > severity(m_worst[bid])) m_worst[bid] = bresp;
                    if (m_done[bid] == q_tot[bid][0]) begin
                        comp = 1'b1;
                        c_resp = m_worst[bid];
                        void'(q_tot[bid].pop_front());
                        m_done[bid]  = 0;
                        m_worst[bid] = 2'd1;
                    end
                end
            end
            if (awv && awr) begin
                if (awtot == 3'd0) err = 1'b1;
                else q_tot[awid].push_back(int'(awtot));
            end
            if (comp) begin
                exp_mv = 1'b1; exp_bid = bid; exp_resp = c_resp;
            end else if (mr) begin
                exp_mv = 1'b0;
            end
            exp_err = err;
            if (err && exp_cnt < 65535) exp_cnt++;
        end
        chk("m_b_valid", 32'(m_b_valid), 32'(exp_mv));
        chk("m_bid", 32'(m_bid), 32'(exp_bid));
        chk("m_bresp", 32'(m_bresp), 32'(exp_resp));
        chk("err_unexp", 32'(err_unexp), 32'(exp_err));
`ifdef BRESP_MERGE_ERR_CNT_EN
        chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
`endif
    endtask

    typedef struct {
        logic       awv;
        logic [2:0] awid;
        logic [2:0] awtot;
        logic       bv;
        logic [2:0] bid;
        logic [1:0] bresp;
        logic       emv;
        logic [2:0] ebid;
        logic [1:0] eresp;
        logic       eerr;
    } vec_t;

    vec_t tbl [26];

    initial begin
        // awv id tot | bv id resp | exp mv id resp err
        tbl[0]  = '{1'b1, 3'd1, 3'd3, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 3'd2, 3'd2, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[2]  = '{1'b1, 3'd3, 3'd4, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[3]  = '{1'b1, 3'd1, 3'd5, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[4]  = '{1'b1, 3'd2, 3'd2, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[5]  = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[6]  = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 2'd2, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[7]  = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 2'd0, 1'b1, 3'd1, 2'd2, 1'b0};
        tbl[8]  = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[9]  = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 2'd2, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[11] = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[12] = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd1, 2'd0, 1'b1, 3'd1, 2'd2, 1'b0};
        tbl[13] = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd2, 2'd1, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[14] = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd2, 2'd1, 1'b1, 3'd2, 2'd1, 1'b0};
        tbl[15] = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd2, 2'd1, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[16] = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd2, 2'd3, 1'b1, 3'd2, 2'd3, 1'b0};
        tbl[17] = '{1'b1, 3'd0, 3'd2, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[18] = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 2'd1, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[19] = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 2'd1, 1'b1, 3'd0, 2'd1, 1'b0};
        tbl[20] = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd7, 2'd0, 1'b0, 3'd0, 2'd0, 1'b1};
        tbl[21] = '{1'b1, 3'd4, 3'd0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b1};
        tbl[22] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0};
        tbl[23] = '{1'b1, 3'd6, 3'd1, 1'b1, 3'd6, 2'd0, 1'b0, 3'd0, 2'd0, 1'b1};
        tbl[24] = '{1'b0, 3'd0, 3'd0, 1'b1, 3'd6, 2'd2, 1'b1, 3'd6, 2'd2, 1'b0};
        tbl[25] = '{1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0};

        model_reset();
        step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b1);
        step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b1);
        chk("reset_aw_ready", 32'(aw_ready), 32'd1);

        // Directed vector table
        for (int i = 0; i < 26; i++) begin
            step(1'b0, tbl[i].awv, tbl[i].awid, tbl[i].awtot, tbl[i].bv, tbl[i].bid,
                 tbl[i].bresp, 1'b1);
            $display("vec %0d: aw=%0b id%0d tot%0d b=%0b id%0d resp%0d -> m_b_valid=%0b bid=%0d bresp=%0d err=%0b",
                     i, tbl[i].awv, tbl[i].awid, tbl[i].awtot, tbl[i].bv, tbl[i].bid,
                     tbl[i].bresp, m_b_valid, m_bid, m_bresp, err_unexp);
            chk("tbl_m_b_valid", 32'(m_b_valid), 32'(tbl[i].emv));
            if (tbl[i].emv) begin
                chk("tbl_m_bid", 32'(m_bid), 32'(tbl[i].ebid));
                chk("tbl_m_bresp", 32'(m_bresp), 32'(tbl[i].eresp));
            end
            chk("tbl_err_unexp", 32'(err_unexp), 32'(tbl[i].eerr));
        end
`ifdef BRESP_MERGE_ERR_CNT_EN
        chk("tbl_err_cnt", 32'(err_cnt), 32'd3);
`endif

        // Backpressure: completion held while upstream stalls, id3 beats wait
        step(1'b0, 1'b1, 3'd2, 3'd1, 1'b0, 3'd0, 2'd0, 1'b1);
        step(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd2, 2'd2, 1'b0);
        $display("bp: completion id2 -> m_b_valid=%0b bid=%0d bresp=%0d", m_b_valid, m_bid, m_bresp);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd3, 2'd0, 1'b0);
            chk("bp_s_b_ready_low", 32'(s_b_ready), 32'd0);
            chk("bp_hold_bid", 32'(m_bid), 32'd2);
            chk("bp_hold_bresp", 32'(m_bresp), 32'd2);
            chk("bp_hold_valid", 32'(m_b_valid), 32'd1);
        end
        m_b_ready = 1'b1;
        #1;
        chk("bp_s_b_ready_release", 32'(s_b_ready), 32'd1);
        step(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd3, 2'd0, 1'b1);
        chk("bp_after_handshake", 32'(m_b_valid), 32'd0);

        // Full queue on id5, independent id6
        step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 3'd5, 3'd1, 1'b0, 3'd0, 2'd0, 1'b1);
            $display("full: AW id5 #%0d accepted", k + 1);
        end
        aw_valid = 1'b1; aw_id = 3'd6;
        #1;
        chk("full_aw_ready_id6", 32'(aw_ready), 32'd1);
        aw_id = 3'd5;
        #1;
        chk("full_aw_ready_id5", 32'(aw_ready), 32'd0);
        step(1'b0, 1'b1, 3'd5, 3'd2, 1'b1, 3'd5, 2'd0, 1'b1);
        chk("full_reopen", 32'(aw_ready), 32'd1);
        chk("full_done_valid", 32'(m_b_valid), 32'd1);

        // Reset in flight with two writes outstanding and a pending merged response
        step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b1);
        step(1'b0, 1'b1, 3'd1, 3'd1, 1'b0, 3'd0, 2'd0, 1'b1);
        step(1'b0, 1'b1, 3'd2, 3'd2, 1'b0, 3'd0, 2'd0, 1'b1);
        step(1'b0, 1'b1, 3'd3, 3'd2, 1'b1, 3'd1, 2'd3, 1'b0);
        chk("rst_pre_valid", 32'(m_b_valid), 32'd1);
        step(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b0);
        $display("rst: m_b_valid=%0b bid=%0d bresp=%0d err=%0b", m_b_valid, m_bid, m_bresp, err_unexp);
        aw_id = 3'd2; arst = 1'b0;
        #1;
        chk("rst_aw_ready_id2", 32'(aw_ready), 32'd1);
        aw_id = 3'd3;
        #1;
        chk("rst_aw_ready_id3", 32'(aw_ready), 32'd1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            logic       r_awv, r_bv, r_mr;
            logic [2:0] r_awid, r_tot, r_bid;
            logic [1:0] r_resp;
            r_awv  = ($urandom_range(0, 99) < 18);
            r_awid = 3'($urandom_range(0, 3));
            r_tot  = ($urandom_range(0, 19) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            r_bv   = ($urandom_range(0, 99) < 65);
            r_bid  = 3'($urandom_range(0, 3));
            r_resp = 2'($urandom_range(0, 3));
            r_mr   = ($urandom_range(0, 99) < 70);
            step(1'b0, r_awv, r_awid, r_tot, r_bv, r_bid, r_resp, r_mr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
